// File: rtl/deserializer_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
// Optional partial-word flush is built in when DESER_FLUSH_EN is defined.
package deserializer_pkg;

  localparam int DESER_WIDTH       = 16;
  localparam int DESER_GAP_TIMEOUT = 8;

  // Bit counter must represent 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deser_state_e;

endpackage

// File: rtl/deserializer_if.sv
// Serial input and valid/ready word output of the deserializer, with
// slave (deserializer side) and master (environment side) modports.
interface deserializer_if
  import deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
);
  localparam int CNT_W = cnt_width(WIDTH);

  logic             ser_data_i;
  logic             ser_data_val_i;
  logic [WIDTH-1:0] deser_data_o;
  logic [CNT_W-1:0] deser_data_mod_o;
  logic             deser_data_val_o;
  logic             deser_ready_i;

  modport slave (
    input  ser_data_i,
    input  ser_data_val_i,
    input  deser_ready_i,
    output deser_data_o,
    output deser_data_mod_o,
    output deser_data_val_o
  );

  modport master (
    output ser_data_i,
    output ser_data_val_i,
    output deser_ready_i,
    input  deser_data_o,
    input  deser_data_mod_o,
    input  deser_data_val_o
  );

endinterface

// File: rtl/deserializer_out_reg.sv
// One-word valid/ready holding register; a word arriving while the held
// word is neither empty nor being accepted is dropped with an overflow pulse.
module deser_out_reg
  import deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic [CNT_W-1:0] mod_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] mod_o,
  output logic             val_o,
  output logic             overflow_o
);

  logic accept;
  assign accept = val_o & ready_i;

  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o     <= '0;
      mod_o      <= '0;
      val_o      <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      if (load_i && (!val_o || accept)) begin
        data_o <= word_i;
        mod_o  <= mod_i;
        val_o  <= 1'b1;
      end else if (load_i) begin
        overflow_o <= 1'b1;
      end else if (accept) begin
        val_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel converter with a one-word output buffer.
// Define DESER_FLUSH_EN to emit partial words after GAP_TIMEOUT idle cycles.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int WIDTH       = DESER_WIDTH,
  parameter int GAP_TIMEOUT = DESER_GAP_TIMEOUT
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  deserializer_if.slave  bus,
  output logic           overflow_o,
  output logic           busy_o
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_MOD = CNT_W'(WIDTH);

  if (WIDTH < 3 || GAP_TIMEOUT < 1) begin : g_param_check
    $error("deserializer: WIDTH must be >= 3 and GAP_TIMEOUT >= 1");
  end

  deser_state_e     state;
  // Only WIDTH-1 bits are stored; the final bit joins the word live.
  logic [WIDTH-2:0] shreg;
  logic [CNT_W-1:0] cnt;

  logic             bit_in;
  logic             word_done;
  logic [WIDTH-1:0] full_word;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic [CNT_W-1:0] load_mod;

  assign bit_in    = bus.ser_data_val_i;
  assign word_done = bit_in && (cnt == LAST_CNT);
  assign full_word = {shreg, bus.ser_data_i};

`ifdef DESER_FLUSH_EN
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             flush;
  logic [WIDTH-2:0] part_bits;

  assign flush = (state == COLLECT) && !bit_in &&
                 (gap_cnt == GAP_W'(GAP_TIMEOUT - 1));

  // Stale bits from the previous word sit above the live count; mask them.
  always_comb begin
    // NOTE: default first so no path leaves part_bits unassigned (no latch).
    part_bits = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      part_bits[i] = shreg[i] & (CNT_W'(i) < cnt);
    end
  end

  assign load      = word_done || flush;
  assign load_word = word_done ? full_word : {1'b0, part_bits};
  assign load_mod  = word_done ? FULL_MOD : cnt;
`else
  assign load      = word_done;
  assign load_word = full_word;
  assign load_mod  = FULL_MOD;
`endif

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      // NOTE: shreg is reset too, so a word restarted after reset never sees X bits.
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
`ifdef DESER_FLUSH_EN
      gap_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bit_in) begin
            shreg  <= {shreg[WIDTH-3:0], bus.ser_data_i};
            cnt    <= CNT_W'(1);
            busy_o <= 1'b1;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (bit_in) begin
            shreg <= {shreg[WIDTH-3:0], bus.ser_data_i};
`ifdef DESER_FLUSH_EN
            gap_cnt <= '0;
`endif
            if (word_done) begin
              cnt    <= '0;
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`ifdef DESER_FLUSH_EN
          else if (flush) begin
            cnt     <= '0;
            gap_cnt <= '0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
`endif
        end
      endcase
    end
  end

  deser_out_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .load_i     (load),
    .word_i     (load_word),
    .mod_i      (load_mod),
    .ready_i    (bus.deser_ready_i),
    .data_o     (bus.deser_data_o),
    .mod_o      (bus.deser_data_mod_o),
    .val_o      (bus.deser_data_val_o),
    .overflow_o (overflow_o)
  );

endmodule
